// File: rtl/itch_encoder_if.sv
// Order-entry and word-stream signals of the ITCH encoder.
// The slave modport is the encoder; the master modport is whoever drives orders and drains words.
interface itch_encoder_if #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 i_valid;
    logic                 o_ready;
    logic [1:0]           i_order_type;
    logic [1:0]           i_stock_symbol;
    logic [31:0]          i_order_id;
    logic [31:0]          i_price;
    logic [15:0]          i_quantity;
    logic                 i_trade_type;
    logic [REG_WIDTH-1:0] o_word;
    logic                 o_word_valid;
    logic                 i_word_ready;
    logic                 o_last;
    logic                 o_drop;
    logic [CNT_WIDTH-1:0] o_msg_count;

    modport slave (
        input  i_valid, i_order_type, i_stock_symbol, i_order_id, i_price,
               i_quantity, i_trade_type, i_word_ready,
        output o_ready, o_word, o_word_valid, o_last, o_drop, o_msg_count
    );

    modport master (
        output i_valid, i_order_type, i_stock_symbol, i_order_id, i_price,
               i_quantity, i_trade_type, i_word_ready,
        input  o_ready, o_word, o_word_valid, o_last, o_drop, o_msg_count
    );
endinterface

// File: rtl/itch_encoder.sv
// Packs one order into a 7-word ITCH-style message and streams it out, word 1 first.
// All outputs are registered; the next word is computed from next-state fields and index.
module itch_encoder #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic          i_clk,
    input logic          i_rst_n,
    itch_encoder_if.slave bus
);
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned LAST_IDX = 6;
    localparam logic [1:0]  T_ADD     = 2'd0;
    localparam logic [1:0]  T_CANCEL  = 2'd1;
    localparam logic [1:0]  T_EXEC    = 2'd2;
    localparam logic [1:0]  T_INVALID = 2'd3;

    typedef enum logic {S_IDLE, S_SEND} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [1:0]           type_q, type_d;
    logic [1:0]           sym_q, sym_d;
    logic [31:0]          id_q, id_d;
    logic [31:0]          px_q, px_d;
    logic [15:0]          qty_q, qty_d;
    logic                 side_q, side_d;
    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 drop_q, drop_d;
    logic [REG_WIDTH-1:0] word_q, word_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 accept;
    logic                 hs;

    function automatic logic [63:0] sym64(input logic [1:0] s);
        logic [63:0] v;
        case (s)
            2'd0:    v = 64'h4141504C20202020;
            2'd1:    v = 64'h414D5A4E20202020;
            2'd2:    v = 64'h474F4F474C202020;
            default: v = 64'h4D53465420202020;
        endcase
        return v;
    endfunction

    // One message word for the given order fields and word index (0 = word 1).
    function automatic logic [31:0] msg_word(
        input logic [1:0]       t,
        input logic [1:0]       s,
        input logic [31:0]      id,
        input logic [31:0]      px,
        input logic [15:0]      qty,
        input logic             side,
        input logic [IDX_W-1:0] idx
    );
        logic [7:0]  typ_byte;
        logic [63:0] sy;
        logic [31:0] w;
        sy = sym64(s);
        case (t)
            T_ADD:    typ_byte = 8'h41;
            T_CANCEL: typ_byte = 8'h58;
            default:  typ_byte = 8'h45;
        endcase
        w = 32'h0;
        case (idx)
            3'd0: w = {typ_byte, 24'h0};
            3'd1: w = {8'h0, id[31:8]};
            3'd2: begin
                w[31:24] = id[7:0];
                if (t == T_ADD)  w[16]   = ~side;
                if (t == T_EXEC) w[7:0]  = qty[15:8];
            end
            3'd3: begin
                if (t == T_ADD)       w = {qty, sy[63:48]};
                else if (t == T_EXEC) w = {qty[7:0], 24'h0};
            end
            3'd4: if (t == T_ADD) w = sy[47:16];
            3'd5: if (t == T_ADD) w = {sy[15:0], px[31:16]};
            3'd6: if (t == T_ADD) w = {px[15:0], 16'h0};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            type_q  <= '0;
            sym_q   <= '0;
            id_q    <= '0;
            px_q    <= '0;
            qty_q   <= '0;
            side_q  <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            type_q  <= type_d;
            sym_q   <= sym_d;
            id_q    <= id_d;
            px_q    <= px_d;
            qty_q   <= qty_d;
            side_q  <= side_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        type_d  = type_q;
        sym_d   = sym_q;
        id_d    = id_q;
        px_d    = px_q;
        qty_d   = qty_q;
        side_d  = side_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        accept  = bus.i_valid & ready_q;
        hs      = valid_q & bus.i_word_ready;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.i_order_type == T_INVALID) begin
                        drop_d = 1'b1;
                    end else begin
                        type_d  = bus.i_order_type;
                        sym_d   = bus.i_stock_symbol;
                        id_d    = bus.i_order_id;
                        px_d    = bus.i_price;
                        qty_d   = bus.i_quantity;
                        side_d  = bus.i_trade_type;
                        idx_d   = '0;
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        idx_d   = '0;
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase

        // Output registers follow the next state so word 1 appears the cycle after accept.
        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_SEND);
        last_d  = valid_d && (idx_d == IDX_W'(LAST_IDX));
        word_d  = valid_d ? REG_WIDTH'(msg_word(type_d, sym_d, id_d, px_d, qty_d, side_d, idx_d))
                          : '0;
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_word_valid = valid_q;
    assign bus.o_word       = word_q;
    assign bus.o_last       = last_q;
    assign bus.o_drop       = drop_q;
    assign bus.o_msg_count  = cnt_q;
endmodule

// File: tb/tb_itch_encoder.sv
// Bench for itch_encoder: directed cases plus random orders against a byte-level message model.
// A second encoder with a 3-bit counter sees identical stimulus so counter wrap is exercised quickly.
module tb_itch_encoder;
    localparam int unsigned SMALL_CNT_W = 3;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    int      checks = 0;
    int      errors = 0;
    longint  cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    itch_encoder_if #(.REG_WIDTH(32), .CNT_WIDTH(16))          bus ();
    itch_encoder_if #(.REG_WIDTH(32), .CNT_WIDTH(SMALL_CNT_W)) bus_s ();

    assign bus_s.i_valid        = bus.i_valid;
    assign bus_s.i_order_type   = bus.i_order_type;
    assign bus_s.i_stock_symbol = bus.i_stock_symbol;
    assign bus_s.i_order_id     = bus.i_order_id;
    assign bus_s.i_price        = bus.i_price;
    assign bus_s.i_quantity     = bus.i_quantity;
    assign bus_s.i_trade_type   = bus.i_trade_type;
    assign bus_s.i_word_ready   = bus.i_word_ready;

    itch_encoder #(.REG_WIDTH(32), .CNT_WIDTH(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    itch_encoder #(.REG_WIDTH(32), .CNT_WIDTH(SMALL_CNT_W)) dut_s (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_s)
    );

    logic [31:0] add_exp  [7] = '{32'h41000000, 32'h00000003, 32'hBA010000, 32'h01BB4141,
                                  32'h504C2020, 32'h20200000, 32'hBABB0000};
    logic [31:0] exec_exp [7] = '{32'h45000000, 32'h00123456, 32'h780000AB, 32'hCD000000,
                                  32'h00000000, 32'h00000000, 32'h00000000};

    logic [31:0] sb_w [$];
    logic        sb_l [$];
    int unsigned exp_cnt = 0;
    bit          mon_en = 1'b0;
    bit          rand_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word = '0;
    logic        prev_last = 1'b0;
    longint      last_done_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: lay the order out as a 28-byte message, then cut it into big-endian words.
    task automatic push_expected(input logic [1:0] t, input logic [1:0] s, input logic [31:0] id,
                                 input logic [31:0] px, input logic [15:0] q, input logic side);
        logic [7:0] b [28];
        string      type_chars;
        string      name;
        type_chars = "AXE";
        for (int i = 0; i < 28; i++) b[i] = 8'h00;
        b[0] = type_chars.getc(int'(t));
        b[5] = id[31:24]; b[6] = id[23:16]; b[7] = id[15:8]; b[8] = id[7:0];
        if (t == 2'd0) begin
            case (s)
                2'd0:    name = "AAPL";
                2'd1:    name = "AMZN";
                2'd2:    name = "GOOGL";
                default: name = "MSFT";
            endcase
            b[9]  = side ? 8'h00 : 8'h01;
            b[12] = q[15:8]; b[13] = q[7:0];
            for (int i = 0; i < 8; i++) b[14+i] = (i < name.len()) ? name.getc(i) : 8'h20;
            b[22] = px[31:24]; b[23] = px[23:16]; b[24] = px[15:8]; b[25] = px[7:0];
        end else if (t == 2'd2) begin
            b[11] = q[15:8]; b[12] = q[7:0];
        end
        for (int k = 0; k < 7; k++) begin
            sb_w.push_back({b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
            sb_l.push_back(k == 6);
        end
    endtask

    // Stream monitor: scoreboard words, stall stability, counters, ready/valid exclusivity.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("ready_and_valid", 64'(bus.o_ready & bus.o_word_valid), 64'd0);
            check("msg_count", 64'(bus.o_msg_count), 64'(16'(exp_cnt)));
            check("msg_count_small", 64'(bus_s.o_msg_count), 64'(SMALL_CNT_W'(exp_cnt)));
            if (prev_stall) begin
                check("stall_valid", 64'(bus.o_word_valid), 64'd1);
                check("stall_word", 64'(bus.o_word), 64'(prev_word));
                check("stall_last", 64'(bus.o_last), 64'(prev_last));
            end
            if (bus.o_word_valid && bus.i_word_ready) begin
                if (sb_w.size() == 0) begin
                    check("unexpected_word", 64'(bus.o_word_valid), 64'd0);
                end else begin
                    logic [31:0] ew;
                    logic        el;
                    ew = sb_w.pop_front();
                    el = sb_l.pop_front();
                    check("word", 64'(bus.o_word), 64'(ew));
                    check("last", 64'(bus.o_last), 64'(el));
                    if (el) begin
                        exp_cnt++;
                        last_done_cyc = cyc;
                    end
                end
            end
            prev_stall = bus.o_word_valid && !bus.i_word_ready;
            prev_word  = bus.o_word;
            prev_last  = bus.o_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        bus.i_word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.i_word_ready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic scramble_inputs();
        bus.i_order_type   = 2'($urandom);
        bus.i_stock_symbol = 2'($urandom);
        bus.i_order_id     = $urandom;
        bus.i_price        = $urandom;
        bus.i_quantity     = 16'($urandom);
        bus.i_trade_type   = 1'($urandom);
    endtask

    // Present an order once the encoder is ready; returns just after the accepting edge.
    task automatic send_order(input logic [1:0] t, input logic [1:0] s, input logic [31:0] id,
                              input logic [31:0] px, input logic [15:0] q, input logic side);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 64'(bus.o_ready), 64'd1);
        bus.i_order_type   = t;
        bus.i_stock_symbol = s;
        bus.i_order_id     = id;
        bus.i_price        = px;
        bus.i_quantity     = q;
        bus.i_trade_type   = side;
        bus.i_valid        = 1'b1;
        if (t != 2'd3) push_expected(t, s, id, px, q, side);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_w.size() != 0 || !bus.o_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(sb_w.size() == 0 && bus.o_ready), 64'd1);
    endtask

    initial begin
        bus.i_valid = 1'b0;
        scramble_inputs();

        // Reset values while reset is held
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.o_ready), 64'd0);
        check("rst_valid", 64'(bus.o_word_valid), 64'd0);
        check("rst_word", 64'(bus.o_word), 64'd0);
        check("rst_last", 64'(bus.o_last), 64'd0);
        check("rst_drop", 64'(bus.o_drop), 64'd0);
        check("rst_count", 64'(bus.o_msg_count), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ready", 64'(bus.o_ready), 64'd1);

        // ADD AAPL with ready held high: exact words and latency
        send_order(2'd0, 2'd0, 32'h000003BA, 32'h0000BABB, 16'h01BB, 1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("add_valid", 64'(bus.o_word_valid), 64'd1);
            check("add_word", 64'(bus.o_word), 64'(add_exp[k]));
            check("add_last", 64'(bus.o_last), 64'(k == 6));
            check("add_busy", 64'(bus.o_ready), 64'd0);
        end
        @(negedge clk);
        check("add_ready_n8", 64'(bus.o_ready), 64'd1);
        check("add_valid_n8", 64'(bus.o_word_valid), 64'd0);
        check("add_count", 64'(bus.o_msg_count), 64'd1);

        // EXECUTE
        send_order(2'd2, 2'($urandom), 32'h12345678, $urandom, 16'hABCD, 1'($urandom));
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("exec_word", 64'(bus.o_word), 64'(exec_exp[k]));
        end
        wait_idle();

        // Invalid type is dropped
        send_order(2'd3, 2'd1, $urandom, $urandom, 16'($urandom), 1'b0);
        @(negedge clk);
        check("drop_pulse", 64'(bus.o_drop), 64'd1);
        check("drop_no_valid", 64'(bus.o_word_valid), 64'd0);
        check("drop_ready", 64'(bus.o_ready), 64'd1);
        check("drop_count", 64'(bus.o_msg_count), 64'd2);
        @(negedge clk);
        check("drop_one_cycle", 64'(bus.o_drop), 64'd0);
        check("drop_no_valid2", 64'(bus.o_word_valid), 64'd0);

        // CANCEL MSFT under random stalls
        rand_ready = 1'b1;
        send_order(2'd1, 2'd3, 32'h00000001, $urandom, 16'($urandom), 1'($urandom));
        wait_idle();
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back ADD GOOGL SELL then CANCEL: one idle cycle between messages
        send_order(2'd0, 2'd2, $urandom, $urandom, 16'($urandom), 1'b1);
        send_order(2'd1, 2'($urandom), $urandom, $urandom, 16'($urandom), 1'($urandom));
        @(negedge clk);
        check("b2b_valid", 64'(bus.o_word_valid), 64'd1);
        check("b2b_gap", 64'(cyc - last_done_cyc), 64'd2);
        wait_idle();

        // Reset while word 4 is on the bus
        send_order(2'd0, 2'($urandom), $urandom, $urandom, 16'($urandom), 1'($urandom));
        repeat (4) @(negedge clk);
        check("pre_rst_word4", 64'(bus.o_word_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        sb_w.delete();
        sb_l.delete();
        exp_cnt = 0;
        #1;
        check("midrst_valid", 64'(bus.o_word_valid), 64'd0);
        check("midrst_count", 64'(bus.o_msg_count), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_valid_edge", 64'(bus.o_word_valid), 64'd0);
        check("midrst_count_small", 64'(bus_s.o_msg_count), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        send_order(2'($urandom_range(0, 2)), 2'($urandom), $urandom, $urandom, 16'($urandom), 1'($urandom));
        @(negedge clk);
        check("restart_w1_last", 64'(bus.o_last), 64'd0);
        wait_idle();

        // Random orders with random back-pressure; the small counter wraps along the way
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send_order(2'($urandom), 2'($urandom), $urandom, $urandom, 16'($urandom), 1'($urandom));
        end
        wait_idle();
        rand_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("final_count", 64'(bus.o_msg_count), 64'(16'(exp_cnt)));
        check("final_count_small", 64'(bus_s.o_msg_count), 64'(SMALL_CNT_W'(exp_cnt)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
